// File: rtl/aes_pkg.sv
// aes_pkg: shared Rijndael helpers for the ShiftRows stage.
package aes_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_INV = 1'b1;

    // 256-bit blocks shift rows 2 and 3 one column further than 128/192-bit blocks.
    function automatic int shift_ofs(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows byte permutation.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              inv,
    input  logic [32*NB-1:0]  s,
    output logic [32*NB-1:0]  s_
);

    localparam int W = 32 * NB;

    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            for (c = 0; c < NB; c++) begin : g_col
                localparam int F = (c + shift_ofs(NB, r)) % NB;
                localparam int I = (c + NB - shift_ofs(NB, r)) % NB;
                assign s_[W-1-8*byte_idx(r, c) -: 8] = (inv == DIR_INV) ?
                    s[W-1-8*byte_idx(r, I) -: 8] : s[W-1-8*byte_idx(r, F) -: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered ShiftRows/InvShiftRows stage with skid buffer and tag sideband.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    logic [W-1:0]     w_perm;
    logic             w_in_xfer;
    logic             w_out_free;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_sk_valid;
    logic [W-1:0]     r_sk_data;
    logic [TAG_W-1:0] r_sk_tag;
    logic             r_in_ready;

    shift_rows_perm #(.NB(NB)) u_perm (
        .inv (in_inv),
        .s   (in_data),
        .s_  (w_perm)
    );

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // The skid slot only fills while in_ready is high, so a drain never coincides with a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_data   <= '0;
            r_sk_tag    <= '0;
            r_in_ready  <= 1'b1;
        end else if (w_out_free) begin
            if (r_sk_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_sk_data;
                r_out_tag   <= r_sk_tag;
                r_sk_valid  <= 1'b0;
                r_in_ready  <= 1'b1;
            end else begin
                r_out_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_out_data <= w_perm;
                    r_out_tag  <= in_tag;
                end
            end
        end else if (w_in_xfer) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= w_perm;
            r_sk_tag   <= in_tag;
            r_in_ready <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed and round-trip checks of shift_rows_pipe for NB = 4, 6 and 8.
module tb_shift_rows_pipe;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_inv, out_ready;
    logic [3:0] in_tag;
    logic [127:0] d4;
    logic [191:0] d6;
    logic [255:0] d8;
    logic rdy4, rdy6, rdy8, ov4, ov6, ov8;
    logic [127:0] od4;
    logic [191:0] od6;
    logic [255:0] od8;
    logic [3:0] ot4, ot6, ot8;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_inv(in_inv),
        .in_tag(in_tag), .in_data(d4), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_tag(ot4));
    shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_inv(in_inv),
        .in_tag(in_tag), .in_data(d6), .out_valid(ov6), .out_ready(out_ready),
        .out_data(od6), .out_tag(ot6));
    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_inv(in_inv),
        .in_tag(in_tag), .in_data(d8), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .out_tag(ot8));

    // Reference permutation; the state occupies the low 32*nb bits of the vector.
    function automatic logic [255:0] ref_perm(input int nb, input logic inv, input logic [255:0] s);
        logic [255:0] o;
        int w, sh, src;
        o = '0;
        w = 32 * nb;
        for (int r = 0; r < 4; r++) begin
            sh = (r == 0) ? 0 : (r == 1) ? 1 : (nb == 8) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c + nb - sh) % nb : (c + sh) % nb;
                o[w-1-8*(4*c+r) -: 8] = s[w-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b1;
        d4 = '0; d6 = '0; d8 = '0;
        #12;
        n_chk++;
        if (ov4 !== 1'b0 || od4 !== '0 || ot4 !== '0 || rdy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: ov=%b od=%h ot=%h rdy=%b, required 0/0/0/1", ov4, od4, ot4, rdy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd5; d4 = FIPS_IN;
        for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b1 || od4 !== FIPS_OUT || ot4 !== 4'd5) begin
            n_fail++;
            $display("FIPS_FAIL_MARK");
        end
        n_chk++;
        if (od8[255:192] !== 64'h00050e1304091217) begin
            n_fail++;
            $display("FAIL nb8_fwd: got %h, required 00050e1304091217", od8[255:192]);
        end
        in_inv = 1'b1; in_tag = 4'd6; d4 = FIPS_OUT;
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b1 || od4 !== FIPS_IN || ot4 !== 4'd6) begin
            n_fail++;
            $display("FAIL fips_inv: got %h tag %h, required %h tag 6", od4, ot4, FIPS_IN);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_fips: out_valid=%b, required 0", ov4);
        end
    endtask

    task automatic test_round_trip();
        logic [255:0] x, e4, e6, e8;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d4 = x[127:0]; d6 = x[191:0]; d8 = x;
            in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'(i);
            e4 = ref_perm(4, 1'b0, {128'b0, d4});
            e6 = ref_perm(6, 1'b0, {64'b0, d6});
            e8 = ref_perm(8, 1'b0, d8);
            @(negedge clk);
            n_chk++;
            if (od4 !== e4[127:0] || od6 !== e6[191:0] || od8 !== e8 ||
                ot4 !== 4'(i) || ot6 !== 4'(i) || ot8 !== 4'(i)) begin
                n_fail++;
                $display("FAIL rt_fwd[%0d]: od4=%h od6=%h od8=%h tags %h/%h/%h, required %h %h %h tag %h",
                         i, od4, od6, od8, ot4, ot6, ot8, e4[127:0], e6[191:0], e8, 4'(i));
            end
            d4 = od4; d6 = od6; d8 = od8;
            in_inv = 1'b1; in_tag = 4'(i + 1);
            @(negedge clk);
            n_chk++;
            if (od4 !== x[127:0] || od6 !== x[191:0] || od8 !== x ||
                ot4 !== 4'(i + 1) || ot6 !== 4'(i + 1) || ot8 !== 4'(i + 1) ||
                !ov4 || !ov6 || !ov8) begin
                n_fail++;
                $display("FAIL rt_inv[%0d]: od4=%h od6=%h od8=%h, required %h", i, od4, od6, od8, x);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [127:0] a, b, cc;
        logic [255:0] t;
        a = 128'h00112233445566778899aabbccddeeff;
        b = 128'h0f0e0d0c0b0a09080706050403020100;
        cc = FIPS_IN;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd1; d4 = a;
        @(negedge clk);
        n_chk++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first: rdy=%b ov=%b, required 1/1", rdy4, ov4);
        end
        in_tag = 4'd2; d4 = b;
        @(negedge clk);
        t = ref_perm(4, 1'b0, {128'b0, a});
        n_chk++;
        if (rdy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: in_ready=%b, required 0", rdy4);
        end
        in_tag = 4'd3; d4 = cc;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_chk++;
            if (ov4 !== 1'b1 || od4 !== t[127:0] || ot4 !== 4'd1 || rdy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: ov=%b od=%h tag=%h rdy=%b, required 1 %h 1 0",
                         k, ov4, od4, ot4, rdy4, t[127:0]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        t = ref_perm(4, 1'b0, {128'b0, b});
        n_chk++;
        if (ov4 !== 1'b1 || od4 !== t[127:0] || ot4 !== 4'd2 || rdy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release2: od=%h tag=%h rdy=%b, required %h 2 1", od4, ot4, rdy4, t[127:0]);
        end
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b1 || od4 !== FIPS_OUT || ot4 !== 4'd3) begin
            n_fail++;
            $display("FAIL stall_release3: od=%h tag=%h, required %h 3", od4, ot4, FIPS_OUT);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_empty: out_valid=%b, required 0", ov4);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] q_d[$];
        logic [3:0] q_t[$];
        logic [255:0] t;
        logic [127:0] ed;
        logic [3:0] et, tg;
        logic inv_n;
        inv_n = 1'b0; tg = 4'd0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            in_inv = inv_n; in_tag = tg;
            d4 = {$urandom, $urandom, $urandom, $urandom};
            if (ov4 && out_ready) begin
                n_chk++;
                if (q_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected output %h tag %h", od4, ot4);
                end else begin
                    ed = q_d.pop_front(); et = q_t.pop_front();
                    if (od4 !== ed || ot4 !== et) begin
                        n_fail++;
                        $display("FAIL b2b[%0d]: got %h tag %h, required %h tag %h", i, od4, ot4, ed, et);
                    end
                end
            end
            if (in_valid && rdy4) begin
                t = ref_perm(4, inv_n, {128'b0, d4});
                q_d.push_back(t[127:0]); q_t.push_back(tg);
                inv_n = ~inv_n; tg = tg + 4'd1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ov4) begin
                n_chk++;
                if (q_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_drain_extra: unexpected output %h", od4);
                end else begin
                    ed = q_d.pop_front(); et = q_t.pop_front();
                    if (od4 !== ed || ot4 !== et) begin
                        n_fail++;
                        $display("FAIL b2b_drain: got %h tag %h, required %h tag %h", od4, ot4, ed, et);
                    end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (q_d.size() != 0 || ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lost: %0d words undelivered, out_valid=%b, required 0/0", q_d.size(), ov4);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd7; d4 = FIPS_IN;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (rdy4 !== 1'b0 || ov4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_full: rdy=%b ov=%b, required 0/1", rdy4, ov4);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ov4 !== 1'b0 || rdy4 !== 1'b1 || od4 !== '0 || ot4 !== '0) begin
            n_fail++;
            $display("FAIL ar_clear: ov=%b rdy=%b od=%h ot=%h, required 0 1 0 0", ov4, rdy4, od4, ot4);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_tag = 4'd9; d4 = FIPS_IN;
        @(negedge clk);
        n_chk++;
        if (ov4 !== 1'b1 || od4 !== FIPS_OUT || ot4 !== 4'd9) begin
            n_fail++;
            $display("FAIL ar_first: ov=%b od=%h tag=%h, required 1 %h 9", ov4, od4, ot4, FIPS_OUT);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_round_trip();
        test_stall();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, registered ShiftRows / InvShiftRows stage for Rijndael block widths of 128, 192 and 256 bits. The direction is selected per transaction. The stage sits between the SubBytes and MixColumns stages of the iterative cipher datapath, on both the encrypt and decrypt paths. It has a valid/ready handshake, a skid buffer, full throughput, and a sideband tag that travels with the data.

## Interface
Parameters:
- `NB`, default 4: state columns. Legal values are 4, 6 and 8. Any other value fails elaboration.
- `TAG_W`, default 4: width of the sideband tag. Must be at least 1.

Ports (W = 32*NB):
- `clk`, in, 1: the only clock. All logic samples on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input transaction present.
- `in_ready`, out, 1: stage can accept. Driven from a register.
- `in_inv`, in, 1: 0 selects ShiftRows, 1 selects InvShiftRows.
- `in_tag`, in, TAG_W: opaque sideband, passed through unchanged.
- `in_data`, in, W: state. Byte k = 4*c + r occupies bits [W-1-8k -: 8]; byte 0 is the MSB.
- `out_valid`, out, 1: output transaction present.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, W: permuted state.
- `out_tag`, out, TAG_W: tag belonging to `out_data`.

## Operation
- Row shift offsets sh(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c + sh(r)) mod NB).
- Inverse: out(r,c) = in(r, (c − sh(r)) mod NB).
- Row 0 is never moved. Each output byte is a pure byte select; there is no arithmetic. The column index wraps modulo NB.
- The permutation is applied on the input side. Both buffers store already-permuted data.
- Main output register: `out_valid`, `out_data`, `out_tag`.
- Skid register: `sk_valid`, `sk_data`, `sk_tag`.
- `in_ready` = !`sk_valid`, registered.
- An input transfer occurs when `in_valid` && `in_ready`. An output transfer occurs when `out_valid` && `out_ready`.
- Per-cycle update:
  - Output register empty, or output transfer this cycle: load from the skid register if `sk_valid`, otherwise from the input if an input transfer occurs. Otherwise `out_valid` goes to 0.
  - Output register full and stalled, with an input transfer: the permuted input goes to the skid register and `sk_valid` = 1.
  - Skid drained into the output register: `sk_valid` = 0, unless a simultaneous input transfer refills it. That refill is legal only while `in_ready` was 1, so it cannot happen.
- Transactions are never dropped, duplicated or reordered. `in_inv` and `in_tag` are sampled together with `in_data`.

## Timing
- Reset values while `rst_n` = 0: `out_valid` = 0, `out_data` = 0, `out_tag` = 0, `sk_valid` = 0, `in_ready` = 1.
- Reset mid-stream discards both buffered words immediately, because the reset is asynchronous.
- Latency: 1 cycle. Data accepted on edge N is on `out_data` after edge N with `out_valid` = 1.
- Throughput: 1 transaction per cycle while `out_ready` = 1.
- Stall: the first blocked word is held in the output register and the next one in the skid register. `in_ready` falls on the following edge. At most 2 words are buffered.
- Recovery: after `out_ready` returns to 1, `in_ready` returns to 1 on the edge that drains the skid register.
- While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_tag` hold stable.
- `in_ready` does not depend combinationally on `out_ready`.

## Structure
- Shared package `aes_pkg`:
  - Shift-offset function `shift_ofs(nb, r)`.
  - Byte-index helper `byte_idx(r, c)`.
  - Direction constants `DIR_FWD` = 0 and `DIR_INV` = 1.
- One sub-module, `shift_rows_perm`: combinational, parameter NB, inputs `inv` and `s`, output `s_`, built as a generate loop over r and c. Its output feeds both the output-register load path and the skid-register load path.

## Test plan
- FIPS-197 App. B, NB=4:
  - Forward: `in_data` = d42711aee0bf98f1b8b45de51e415230 → `out_data` = d4bf5d30e0b452aeb84111f11e2798e5, 1 cycle later.
  - Inverse: the same vector with `in_inv` = 1 returns d42711ae…5230.
- NB=8, forward, `in_data` bytes 00..1f in order → first 8 output bytes are 00 05 0e 13 04 09 12 17.
- Random forward then inverse round trip, NB = 4, 6 and 8, 1000 vectors each → output equals the original input. Tags are preserved and in order.
- Stall: streaming with `out_ready` = 0 for 5 cycles → `in_ready` = 0 one cycle after the second accept. Output is stable while stalled. Release delivers the transactions with tags 1, 2, 3 in order with no loss.
- Back-to-back traffic with random `out_ready`, and `in_inv` alternating per beat → each output matches the reference model for its own direction.
- `rst_n` asserted with both buffers full → `out_valid` = 0 and `in_ready` = 1 with no clock edge. The first post-reset input appears 1 cycle after it is accepted.
